bht_redirect_ctrl: RTL
======================

Name: bht_redirect_ctrl

Overview:
Sequences branch-history-table maintenance and front-end redirection for the 5-stage pipeline. It accepts branch resolutions from EX and classifies each one as a correct prediction or a mispredict. On a mispredict it drives a registered redirect and a multi-cycle flush. It also queues the table updates and hands them to the BHT one at a time over a valid/ready handshake, so EX never has to wait on the table's write timing.

Parameters:
UPD_DEPTH, 4, update queue entries (power of two, 2..16)
FLUSH_CYCLES, 2, cycles pipe_flush stays high per mispredict (1..7)
CNT_W, 16, width of the statistics counters

Ports:
clk_sys  in  1  system clock; all state updates on posedge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a resolved control-transfer instruction
ex_pc  in  32  PC of the resolved instruction
ex_is_branch  in  1  instruction is a conditional branch/jump (BHT-tracked)
ex_taken  in  1  actual outcome
ex_target  in  32  actual taken target
ex_pred_taken  in  1  prediction carried down from IF
ex_pred_target  in  32  predicted target carried down from IF
ex_accept  out  1  resolution consumed this cycle
redirect_valid  out  1  one-cycle pulse: fetch restarts at redirect_pc
redirect_pc  out  32  corrected fetch address
pipe_flush  out  1  squash IF/ID/EX wrong-path instructions
upd_valid  out  1  update entry presented to BHT
upd_ready  in  1  BHT accepts update this cycle
upd_pc  out  32  branch PC to update
upd_target  out  32  resolved target
upd_taken  out  1  resolved outcome (increment/decrement history)
mispredict_cnt  out  CNT_W  saturating mispredict count
branch_cnt  out  CNT_W  saturating accepted-branch count

Behaviour:
- Reset (rst sampled high on posedge): all outputs 0; queue empty; FSM in RUN; counters 0. Reset mid-flush or with a full queue discards all state.
- Mispredict on an accepted resolution when either:
  - ex_pred_taken != ex_taken, or
  - ex_pred_taken && ex_taken && ex_pred_target != ex_target.
- Correct PC for a mispredict: ex_taken ? ex_target : ex_pc + 4, using 32-bit wrap-around addition.
- ex_accept = ex_valid && state==RUN && (!ex_is_branch || !queue_full). It is combinational.
- Non-branch resolution (ex_is_branch=0) is accepted without enqueue, but a mispredict on it still redirects.
- FSM states:
  - RUN: on an accepted mispredict, next cycle redirect_valid=1, redirect_pc=correct PC, pipe_flush=1, and the FSM goes to FLUSH with flush counter = FLUSH_CYCLES-1.
  - FLUSH: pipe_flush=1 and ex_accept=0. ex_valid is ignored because those instructions are wrong-path. The counter decrements each cycle; on reaching 0 the FSM returns to RUN next cycle. With FLUSH_CYCLES=1 the FSM returns to RUN immediately after the redirect cycle.
  - redirect_valid is high for exactly one cycle per mispredict.
- Redirect latency: exactly 1 cycle from the accepting edge.
- Update queue behaviour:
  - Every accepted branch resolution, predicted or not, enqueues {ex_pc, ex_target, ex_taken} at the accepting edge.
  - The head entry is presented registered: upd_valid=1 when the queue is non-empty.
  - The head is popped on upd_valid && upd_ready.
  - Simultaneous push and pop when full is not allowed, because accept requires !full. Simultaneous push and pop when non-full keeps occupancy constant.
  - An empty queue gives upd_valid=0 and the other upd_* outputs hold their last values.
  - Pointers wrap modulo UPD_DEPTH; occupancy is tracked in a log2(UPD_DEPTH)+1 bit counter.
  - Queue contents continue draining during FLUSH, since they are architecturally resolved.
- Counters:
  - branch_cnt increments on each accepted branch.
  - mispredict_cnt increments on each accepted mispredict, whether branch or not.
  - Both saturate at all-ones and do not wrap.
- Ordering: updates reach the BHT in resolution order. No update is ever dropped.

Test Plan:
- Correct taken prediction: ex_pc=0x100, taken, target=0x200, pred_taken=1, pred_target=0x200, upd_ready=1 -> ex_accept=1, no redirect/flush, upd_valid next cycle with pc=0x100, taken=1, target=0x200; branch_cnt=1, mispredict_cnt=0.
- Not-predicted taken: pc=0x40, taken, target=0x80, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x80; pipe_flush high 2 cycles; ex_valid during those 2 cycles gives ex_accept=0; mispredict_cnt=1.
- Predicted taken, actually not taken: pc=0xFFFFFFFC, pred_taken=1, taken=0 -> redirect_pc=0x00000000 (wrap-around); update entry has taken=0.
- Target mismatch: both taken, pred_target=0x300, target=0x304 -> redirect to 0x304.
- Backpressure: upd_ready=0, 5 back-to-back correct branches -> first 4 accepted; 5th sees ex_accept=0 until upd_ready=1 for one cycle, then accepted; drain order matches issue order.
- Reset mid-flush with 3 queued entries -> next cycle pipe_flush=0, upd_valid=0, counters 0, new resolution accepted immediately.

Source files
------------

// File: rtl/bht_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bht_redirect_ctrl
//  Purpose  : Classifies EX branch resolutions, issues a registered redirect
//             plus a multi-cycle flush on mispredict, and queues BHT updates
//             that drain to the table over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module bht_redirect_ctrl #(
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              ex_accept,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              pipe_flush,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [31:0]       upd_pc,
    output logic [31:0]       upd_target,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  mispredict_cnt,
    output logic [CNT_W-1:0]  branch_cnt
);

    localparam int             c_PTR_W      = $clog2(UPD_DEPTH);
    localparam int             c_OCC_W      = c_PTR_W + 1;
    localparam logic [2:0]     c_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [c_OCC_W-1:0] c_DEPTH  = c_OCC_W'(UPD_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_flush_cnt;
    logic [2:0]           w_flush_cnt_nxt;

    logic [31:0]          r_q_pc  [UPD_DEPTH];
    logic [31:0]          r_q_tgt [UPD_DEPTH];
    logic                 r_q_tkn [UPD_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_count;

    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;
    logic                 r_upd_valid;
    logic [31:0]          r_upd_pc;
    logic [31:0]          r_upd_target;
    logic                 r_upd_taken;
    logic [CNT_W-1:0]     r_mispredict_cnt;
    logic [CNT_W-1:0]     r_branch_cnt;

    logic                 w_full;
    logic                 w_accept;
    logic                 w_mispredict;
    logic                 w_take_mispredict;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_correct_pc;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_OCC_W-1:0]   w_remain;
    logic [c_OCC_W-1:0]   w_count_nxt;

    // Resolution classification, acceptance and queue push/pop strobes.
    always_comb begin
        w_full            = (r_count == c_DEPTH);
        w_accept          = ex_valid && (r_state == ST_RUN) && (!ex_is_branch || !w_full);
        w_mispredict      = (ex_pred_taken != ex_taken) ||
                            (ex_pred_taken && ex_taken && (ex_pred_target != ex_target));
        w_take_mispredict = w_accept && w_mispredict;
        w_correct_pc      = ex_taken ? ex_target : (ex_pc + 32'd4);
        w_push            = w_accept && ex_is_branch;
        w_pop             = r_upd_valid && upd_ready;
        w_rd_ptr_nxt      = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;
        // Entries remaining after this cycle's pop, excluding the push.
        w_remain          = w_pop ? (r_count - c_OCC_W'(1)) : r_count;
        w_count_nxt       = w_push ? (w_remain + c_OCC_W'(1)) : w_remain;
    end

    // FSM state register with flush down-counter.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state logic: enter FLUSH on an accepted mispredict, leave when the counter hits 0.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_take_mispredict) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    // One-cycle redirect pulse carrying the corrected fetch address.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_redirect_valid <= w_take_mispredict;
            if (w_take_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
        end
    end

    // Queue storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]  <= ex_pc;
            r_q_tgt[r_wr_ptr] <= ex_target;
            r_q_tkn[r_wr_ptr] <= ex_taken;
        end
    end

    // Queue pointers, occupancy, and the registered head presented to the BHT.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_pc     <= 32'd0;
            r_upd_target <= 32'd0;
            r_upd_taken  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_upd_valid <= (w_count_nxt != '0);
            // Empty-after-pop plus a push means the new entry becomes head directly.
            if (w_count_nxt != '0) begin
                if (w_remain == '0) begin
                    r_upd_pc     <= ex_pc;
                    r_upd_target <= ex_target;
                    r_upd_taken  <= ex_taken;
                end else begin
                    r_upd_pc     <= r_q_pc[w_rd_ptr_nxt];
                    r_upd_target <= r_q_tgt[w_rd_ptr_nxt];
                    r_upd_taken  <= r_q_tkn[w_rd_ptr_nxt];
                end
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_push && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_take_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_accept      = w_accept;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign pipe_flush     = (r_state == ST_FLUSH);
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_target     = r_upd_target;
    assign upd_taken      = r_upd_taken;
    assign mispredict_cnt = r_mispredict_cnt;
    assign branch_cnt     = r_branch_cnt;

endmodule
`default_nettype wire
